// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: serialises a captured word MSB first and counts (overlapping) 4-bit pattern matches.
// Optional macro PATTERN_PROG_EN adds a 4-bit pattern input sampled when a scan is accepted.
`default_nettype none

module seq_scan_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] din_word,
`ifdef PATTERN_PROG_EN
  input  logic [3:0]       pattern,
`endif
  output logic             busy,
  output logic             ser_bit,
  output logic             hit,
  output logic             done,
  output logic             found,
  output logic [CNT_W-1:0] match_cnt,
  output logic [4:0]       first_idx
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0]       c_PATTERN   = 4'b0101;
  localparam logic [4:0]       c_NO_MATCH  = 5'd31;
  localparam logic [4:0]       c_LAST_IDX  = 5'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};

  state_t           r_state;
  logic [WIDTH-1:0] r_word;
  logic [4:0]       r_idx;
  logic [2:0]       r_hist;
  logic             r_busy;
  logic             r_ser;
  logic             r_done;
  logic             r_found;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_first;
  logic [3:0]       w_pat;
  logic             w_hit;
  logic             w_last;

`ifdef PATTERN_PROG_EN
  logic [3:0] r_pat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pat <= c_PATTERN;
    end else if (r_state == S_IDLE && start) begin
      r_pat <= pattern;
    end
  end

  assign w_pat = r_pat;
`else
  assign w_pat = c_PATTERN;
`endif

  // r_hist[2] is the oldest bit, so the window lines up with the pattern read left to right
  assign w_hit  = (r_state == S_SHIFT) && !abort && (r_idx >= 5'd3) &&
                  ({r_hist, r_ser} == w_pat);
  assign w_last = (r_idx == c_LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_word  <= '0;
      r_idx   <= '0;
      r_hist  <= '0;
      r_busy  <= 1'b0;
      r_ser   <= 1'b0;
      r_done  <= 1'b0;
      r_found <= 1'b0;
      r_cnt   <= '0;
      r_first <= c_NO_MATCH;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_word  <= din_word;
            r_idx   <= '0;
            r_hist  <= '0;
            r_busy  <= 1'b1;
            r_found <= 1'b0;
            r_cnt   <= '0;
            r_first <= c_NO_MATCH;
          end
        end
        S_LOAD: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_ser   <= 1'b0;
            r_found <= 1'b0;
            r_cnt   <= '0;
            r_first <= c_NO_MATCH;
          end else begin
            r_state <= S_SHIFT;
            r_ser   <= r_word[WIDTH-1];
            r_word  <= r_word << 1;
          end
        end
        S_SHIFT: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_ser   <= 1'b0;
            r_found <= 1'b0;
            r_cnt   <= '0;
            r_first <= c_NO_MATCH;
          end else begin
            r_hist <= {r_hist[1:0], r_ser};
            if (w_hit) begin
              if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
              end
              if (!r_found) begin
                r_found <= 1'b1;
                r_first <= r_idx;
              end
            end
            if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_ser   <= 1'b0;
            end else begin
              r_idx  <= r_idx + 5'd1;
              r_ser  <= r_word[WIDTH-1];
              r_word <= r_word << 1;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign ser_bit   = r_ser;
  assign hit       = w_hit;
  assign done      = r_done;
  assign found     = r_found;
  assign match_cnt = r_cnt;
  assign first_idx = r_first;

endmodule

`default_nettype wire

// File: tb/tb_seq_scan_ctrl.sv
// tb_seq_scan_ctrl: directed and randomized scans of seq_scan_ctrl against a sliding-window reference model.
`default_nettype none

module tb_seq_scan_ctrl;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] din_word = '0;
  logic [3:0]       pattern = 4'b0101;
  logic             busy, ser_bit, hit, done, found;
  logic [CNT_W-1:0] match_cnt;
  logic [4:0]       first_idx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_scan_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .din_word  (din_word),
`ifdef PATTERN_PROG_EN
    .pattern   (pattern),
`endif
    .busy      (busy),
    .ser_bit   (ser_bit),
    .hit       (hit),
    .done      (done),
    .found     (found),
    .match_cnt (match_cnt),
    .first_idx (first_idx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: slide a 4-bit window over the MSB-first stream; window bit 3 is the oldest bit.
  function automatic void model(input logic [WIDTH-1:0] w, input logic [3:0] p,
                                output logic [WIDTH-1:0] hits, output int cnt, output int first);
    logic [WIDTH-1:0] sh;
    hits  = '0;
    cnt   = 0;
    first = 31;
    for (int k = 3; k < WIDTH; k++) begin
      sh = w >> (WIDTH - 1 - k);
      if (sh[3:0] == p) begin
        hits[k] = 1'b1;
        cnt++;
        if (first == 31) first = k;
      end
    end
    if (cnt > (2 ** CNT_W) - 1) cnt = (2 ** CNT_W) - 1;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_hit"},   hit, 0);
    check({tag, "_ser"},   ser_bit, 0);
    check({tag, "_found"}, found, 0);
    check({tag, "_cnt"},   match_cnt, 0);
    check({tag, "_first"}, first_idx, 31);
  endtask

  task automatic run_scan(input logic [WIDTH-1:0] w, input int abort_at, input int start_at,
                          input bit abort_in_done);
    logic [WIDTH-1:0] hits;
    int exp_cnt, exp_first, nh;
    bit saw_done;
    model(w, pattern, hits, exp_cnt, exp_first);
    din_word = w;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("load_busy", busy, 1);
    check("load_cnt_clear", match_cnt, 0);
    check("load_first_clear", first_idx, 31);
    @(posedge clk); #1;
    nh = 0;
    for (int k = 0; k < WIDTH; k++) begin
      if (k == abort_at) begin
        abort = 1'b1;
        #1;
        check("abort_hit_gated", hit, 0);
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_cnt", match_cnt, 0);
        check("abort_found", found, 0);
        check("abort_first", first_idx, 31);
        saw_done = 1'b0;
        repeat (WIDTH + 3) begin
          @(posedge clk); #1;
          if (done) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);
        return;
      end
      check("ser_bit", ser_bit, w[WIDTH-1-k]);
      check("hit", hit, hits[k]);
      if (hit) nh++;
      if (k == start_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("done_not_early", done, 0);
    check("done_state_busy", busy, 0);
    if (abort_in_done) abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("done_pulse", done, 1);
    check("match_cnt", match_cnt, exp_cnt);
    check("found", found, (exp_cnt > 0) ? 1 : 0);
    check("first_idx", first_idx, exp_first);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("cnt_held", match_cnt, exp_cnt);
    check("hit_pulses", nh, $countones(hits));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int a_at, s_at;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    reset = 1'b0;

    run_scan(16'h5555, -1, -1, 1'b0);
    run_scan(16'hFFFF, -1, -1, 1'b0);
    run_scan(16'h0005, -1, -1, 1'b0);
    run_scan(16'h5555, 5, -1, 1'b0);
    run_scan(16'h5555, -1, -1, 1'b0);
    run_scan(16'h5555, -1, 4, 1'b1);

    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("idle_abort_cnt", match_cnt, 7);
    check("idle_abort_first", first_idx, 3);
    check("idle_abort_busy", busy, 0);

    din_word = 16'h5555;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("pre_reset_cnt", match_cnt, 3);
    reset = 1'b1;
    #1;
    check_reset_values("midscan_reset");
    @(negedge clk);
    reset = 1'b0;

`ifdef PATTERN_PROG_EN
    pattern = 4'b1111;
    run_scan(16'hFFFF, -1, -1, 1'b0);
    check("prog_cnt_13", match_cnt, 13);
    pattern = 4'b0101;
`endif

    for (int n = 0; n < 30; n++) begin
`ifdef PATTERN_PROG_EN
      pattern = 4'($urandom);
`endif
      a_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WIDTH - 1)) : -1;
      s_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, WIDTH - 1)) : -1;
      run_scan(WIDTH'($urandom), a_at, s_at, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, bits per scanned word (legal range 4..31).
REQ-002 SHALL have parameter CNT_W, default 5, width of match_cnt.
REQ-003 SHALL have one clock; reset is asynchronous and active-high; ports named clk and reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 start  input  1  scan request, sampled in IDLE only.
REQ-007 abort  input  1  terminate scan in progress.
REQ-008 din_word  input  WIDTH  word to scan, transmitted MSB first.
REQ-009 busy  output  1  high while in LOAD or SHIFT.
REQ-010 ser_bit  output  1  bit presented to the detector this cycle.
REQ-011 hit  output  1  one-cycle pulse on each pattern match.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 found  output  1  at least one match in last completed scan.
REQ-014 match_cnt  output  CNT_W  match count of last scan.
REQ-015 first_idx  output  5  stream index (0-based) of the last bit of the first match; 5'd31 if none.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE; reset state IDLE.
REQ-017 IDLE: start=1 -> LOAD; capture din_word; clear bit index, 3-bit history, match_cnt, found; set first_idx=31.
REQ-018 LOAD: one cycle -> SHIFT; busy=1.
REQ-019 SHIFT: one bit per cycle, index 0..WIDTH-1, ser_bit = captured word bit [WIDTH-1-index].
REQ-020 Match condition: previous 3 bits plus current bit equal the pattern (oldest bit first); fixed pattern 0101.
REQ-021 Overlapping matches SHALL count; a match requires index >= 3 (history cleared per scan).
REQ-022 On match: hit=1 that cycle (combinational from state, history and current bit); match_cnt increments, saturating at 2^CNT_W-1; first_idx and found updated on the first match only.
REQ-023 After index WIDTH-1 -> DONE; DONE asserts done for exactly one cycle -> IDLE.
REQ-024 Latency: start sampled at edge E0 -> done high between edges E(WIDTH+2) and E(WIDTH+3).
REQ-025 start in LOAD, SHIFT or DONE SHALL be ignored (not queued).
REQ-026 abort in LOAD or SHIFT -> IDLE at the next edge; no done; match_cnt, found and first_idx return to reset values; abort has priority over bit processing.
REQ-027 abort in IDLE or DONE SHALL have no effect.
REQ-028 match_cnt, found and first_idx SHALL hold after DONE until the next accepted start.

Reset
REQ-029 reset asserted at any time, including mid-scan -> state IDLE immediately.
REQ-030 Reset values: busy=0, done=0, hit=0, ser_bit=0, found=0, match_cnt=0, first_idx=31.
REQ-031 First accepted start SHALL be on the first rising edge after reset deassertion.

Configuration
REQ-032 With PATTERN_PROG_EN defined: add input pattern[3:0], sampled at start acceptance and used for REQ-020.
REQ-033 Without PATTERN_PROG_EN: no pattern port; pattern fixed at 0101.

Verification
REQ-034 din_word=16'h5555 -> matches at idx 3,5,...,15; match_cnt=7, found=1, first_idx=3, 7 hit pulses.
REQ-035 din_word=16'hFFFF -> match_cnt=0, found=0, first_idx=31, no hit, done 1 cycle.
REQ-036 din_word=16'h0005 -> match_cnt=1, first_idx=15; done between E18 and E19 after start at E0.
REQ-037 abort at SHIFT index 5 of 16'h5555 -> busy=0 next cycle, no done, match_cnt=0; new start then gives match_cnt=7.
REQ-038 start pulsed during SHIFT ignored; reset at SHIFT index 8 -> all outputs at reset values, busy=0.
REQ-039 PATTERN_PROG_EN with pattern=4'b1111, din_word=16'hFFFF -> match_cnt=13, first_idx=3.
